// File: rtl/ifetch_pkg.sv
// ifetch_pkg: definitions shared by the instruction fetch sequencer and its queue.
//   INSTR_W / ADDR_W : instruction and byte-address widths
//   fetch_state_e    : sequencer states (IDLE, FETCH, END, FAULT)
//   fetch_entry_t    : one queued fetch, {pc, instr}
//   WORD_ALIGN       : low address bits required for a word-aligned target
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [1:0] WORD_ALIGN = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_END   = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == WORD_ALIGN;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry FIFO of fetched {pc, instr} words.
//   clk, reset_i : clock and synchronous active-high reset
//   push_i       : enqueue entry_i (accepted when not full, or full with a pop)
//   pop_i        : drop the head (ignored when empty)
//   flush_i      : empty the queue; wins over push and pop
//   entry_i      : entry to enqueue
//   head_o       : head entry; holds its last value while the queue is empty
//   valid_o      : queue non-empty
//   full_o       : queue holds DEPTH entries
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam logic [1:0] CNT_FULL = 2'(DEPTH);

    // Slot 0 is always the head; slot 1 is the entry behind it.
    fetch_entry_t slot_q [DEPTH];
    fetch_entry_t slot_d [DEPTH];
    logic [1:0]   count_q, count_d;
    logic         pop_ok, push_ok;

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

        if (flush_i) begin
            // Data is left in place so the outputs keep their last value.
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b11: begin
                    if (count_q == CNT_FULL) begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = entry_i;
                    end else begin
                        slot_d[0] = entry_i;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) slot_d[0] = entry_i;
                    else                 slot_d[1] = entry_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves slot 0 untouched (hold).
                    if (count_q == CNT_FULL) slot_d[0] = slot_q[1];
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign head_o  = slot_q[0];
    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == CNT_FULL);

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch sequencer for a byte-addressed, big-endian instruction memory.
//   clk, reset          : clock and synchronous active-high reset
//   run                 : fetch enable
//   iaddr / instruction : address to imemory (the PC) and the word it returns
//   inst_out, inst_pc   : head of the fetch queue and its byte address
//   inst_valid / ready  : handshake to decode; pop when both are high
//   redirect, redirect_pc : taken branch/jump pulse and its target
//   halted              : program exhausted, no more fetches
//   fault, fault_pc     : sticky bad-redirect flag and the offending target
//   fetch_count         : words pushed since reset (wraps)
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned       IMEM_BYTES = 40,
    parameter int                Q_DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] inst_out,
    output logic [ADDR_W-1:0]  inst_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc,
    output logic [31:0]        fetch_count
);

    // One extra bit so pc+4 and the limit compare without wrap-around.
    localparam logic [ADDR_W:0] IMEM_LIMIT = (ADDR_W + 1)'(IMEM_BYTES);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              halted_q;
    logic              fault_q;
    logic [ADDR_W-1:0] fault_pc_q;
    logic [31:0]       fetch_count_q;

    logic              q_valid, q_full;
    fetch_entry_t      q_head, q_entry;
    logic              pop, push, take_redirect, redirect_ok;
    logic [ADDR_W:0]   pc_plus4_wide;

    always_comb begin
        pop           = q_valid && inst_ready;
        take_redirect = redirect && (state_q != ST_FAULT);
        redirect_ok   = is_word_aligned(redirect_pc) && ({1'b0, redirect_pc} < IMEM_LIMIT);
        // A redirect cycle never pushes: the word at the old pc is discarded.
        push          = (state_q == ST_FETCH) && run && !take_redirect && (!q_full || pop);
        pc_plus4_wide = {1'b0, pc_q} + (ADDR_W + 1)'(4);
        q_entry.pc    = pc_q;
        q_entry.instr = instruction;
    end

    ifetch_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (take_redirect),
        .entry_i (q_entry),
        .head_o  (q_head),
        .valid_o (q_valid),
        .full_o  (q_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            if (push) fetch_count_q <= fetch_count_q + 32'd1;

            if (take_redirect) begin
                if (redirect_ok) begin
                    pc_q     <= redirect_pc;
                    halted_q <= 1'b0;
                    // A redirect while idle only moves the pc.
                    if (state_q != ST_IDLE) state_q <= run ? ST_FETCH : ST_IDLE;
                end else begin
                    // pc is frozen at its current value once faulted.
                    state_q    <= ST_FAULT;
                    fault_q    <= 1'b1;
                    fault_pc_q <= redirect_pc;
                    halted_q   <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (run) state_q <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (!run) begin
                            state_q <= ST_IDLE;
                        end else if (push) begin
                            pc_q <= pc_plus4_wide[ADDR_W-1:0];
                            // The last word below the limit was just queued.
                            if (pc_plus4_wide >= IMEM_LIMIT) begin
                                state_q  <= ST_END;
                                halted_q <= 1'b1;
                            end
                        end
                    end
                    ST_END:   ;
                    ST_FAULT: ;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign iaddr       = pc_q;
    assign inst_out    = q_head.instr;
    assign inst_pc     = q_head.pc;
    assign inst_valid  = q_valid;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: a directed vector table, a full-program sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_ifetch_ctrl;

    localparam int unsigned IMEM = 40;

    logic        clk = 1'b0;
    logic        reset, run, inst_ready, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] iaddr, instruction, inst_out, inst_pc, fault_pc, fetch_count;
    logic        inst_valid, halted, fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1357_9BDF ^ (a * 32'h9E37_79B9);
    endfunction

    assign instruction = mem_word(iaddr);

    ifetch_ctrl #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (IMEM),
        .Q_DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .iaddr       (iaddr),
        .instruction (instruction),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, rn, rdy, rdr;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc, eia;
        logic        eh, ef;
        logic [31:0] efpc, ecnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    function automatic vec_t mk(input logic rst, rn, rdy, rdr, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, eia,
                                input logic eh, ef, input logic [31:0] efpc, ecnt);
        vec_t v;
        v.rst = rst; v.rn = rn; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eia = eia; v.eh = eh; v.ef = ef;
        v.efpc = efpc; v.ecnt = ecnt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_DEAD = 3;
    typedef struct { logic [31:0] pc, w; } ent_t;
    ent_t        mq [$];
    int          m_mode;
    logic [31:0] m_pc, m_fpc, m_cnt;
    logic        m_fault;

    task automatic model_step();
        bit popped;
        if (reset) begin
            mq.delete();
            m_mode = M_IDLE; m_pc = 0; m_fpc = 0; m_cnt = 0; m_fault = 0;
            return;
        end
        popped = (mq.size() > 0) && inst_ready;
        if (m_mode != M_DEAD && redirect) begin
            mq.delete();
            if (redirect_pc % 4 == 0 && redirect_pc < IMEM) begin
                m_pc = redirect_pc;
                if (m_mode != M_IDLE) m_mode = run ? M_RUN : M_IDLE;
            end else begin
                m_mode = M_DEAD; m_fault = 1; m_fpc = redirect_pc;
            end
            return;
        end
        if (popped) void'(mq.pop_front());
        if (m_mode == M_IDLE) begin
            if (run) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!run) m_mode = M_IDLE;
            else if (mq.size() < 2) begin
                mq.push_back('{pc: m_pc, w: mem_word(m_pc)});
                m_cnt++;
                if (m_pc + 4 >= IMEM) m_mode = M_DONE;
                m_pc += 4;
            end
        end
    endtask

    initial begin
        reset = 1; run = 0; inst_ready = 0; redirect = 0; redirect_pc = 0;

        //           rst run rdy rdr rpc | ev pc  iaddr h  f  fpc cnt
        vt[0]  = mk(1, 0, 0, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[1]  = mk(0, 1, 0, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[2]  = mk(0, 1, 0, 0, 0,   1, 0,  4,  0, 0, 0,  1);
        vt[3]  = mk(0, 1, 0, 0, 0,   1, 0,  8,  0, 0, 0,  2);
        vt[4]  = mk(0, 1, 0, 0, 0,   1, 0,  8,  0, 0, 0,  2);
        vt[5]  = mk(0, 1, 0, 0, 0,   1, 0,  8,  0, 0, 0,  2);
        vt[6]  = mk(0, 1, 1, 0, 0,   1, 4,  12, 0, 0, 0,  3);
        vt[7]  = mk(0, 1, 1, 0, 0,   1, 8,  16, 0, 0, 0,  4);
        vt[8]  = mk(0, 1, 1, 1, 20,  0, 0,  20, 0, 0, 0,  4);
        vt[9]  = mk(0, 1, 1, 0, 0,   1, 20, 24, 0, 0, 0,  5);
        vt[10] = mk(0, 1, 1, 0, 0,   1, 24, 28, 0, 0, 0,  6);
        vt[11] = mk(0, 1, 1, 0, 0,   1, 28, 32, 0, 0, 0,  7);
        vt[12] = mk(0, 1, 1, 0, 0,   1, 32, 36, 0, 0, 0,  8);
        vt[13] = mk(0, 1, 1, 0, 0,   1, 36, 40, 1, 0, 0,  9);
        vt[14] = mk(0, 1, 1, 0, 0,   0, 0,  40, 1, 0, 0,  9);
        vt[15] = mk(0, 1, 1, 1, 8,   0, 0,  8,  0, 0, 0,  9);
        vt[16] = mk(0, 1, 1, 0, 0,   1, 8,  12, 0, 0, 0,  10);
        vt[17] = mk(0, 1, 1, 1, 22,  0, 0,  12, 0, 1, 22, 10);
        vt[18] = mk(0, 1, 1, 1, 0,   0, 0,  12, 0, 1, 22, 10);
        vt[19] = mk(0, 1, 1, 0, 0,   0, 0,  12, 0, 1, 22, 10);
        vt[20] = mk(1, 1, 1, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[21] = mk(0, 1, 1, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[22] = mk(0, 1, 1, 1, 40,  0, 0,  0,  0, 1, 40, 0);
        vt[23] = mk(1, 1, 1, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[24] = mk(0, 1, 1, 0, 0,   0, 0,  0,  0, 0, 0,  0);
        vt[25] = mk(0, 1, 1, 0, 0,   1, 0,  4,  0, 0, 0,  1);
        vt[26] = mk(1, 1, 1, 0, 0,   0, 0,  0,  0, 0, 0,  0);

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; run = vt[i].rn; inst_ready = vt[i].rdy;
            redirect = vt[i].rdr; redirect_pc = vt[i].rpc;
            tick();
            $display("vec %0d: rst=%0b run=%0b rdy=%0b rdr=%0b rpc=%0d -> iaddr=%0d valid=%0b pc=%0d cnt=%0d",
                     i, vt[i].rst, vt[i].rn, vt[i].rdy, vt[i].rdr, vt[i].rpc,
                     iaddr, inst_valid, inst_pc, fetch_count);
            chk($sformatf("vec%0d.iaddr", i), iaddr, vt[i].eia);
            chk($sformatf("vec%0d.valid", i), {31'b0, inst_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d.halted", i), {31'b0, halted}, {31'b0, vt[i].eh});
            chk($sformatf("vec%0d.fault", i), {31'b0, fault}, {31'b0, vt[i].ef});
            chk($sformatf("vec%0d.fault_pc", i), fault_pc, vt[i].efpc);
            chk($sformatf("vec%0d.count", i), fetch_count, vt[i].ecnt);
            if (i == 0) begin
                chk("reset.inst_out", inst_out, 32'h0);
                chk("reset.inst_pc", inst_pc, 32'h0);
            end
            if (vt[i].ev) begin
                chk($sformatf("vec%0d.inst_pc", i), inst_pc, vt[i].epc);
                chk($sformatf("vec%0d.inst_out", i), inst_out, mem_word(vt[i].epc));
            end
        end

        // ---------------- whole program, decode always ready ----------------
        reset = 1; run = 1; inst_ready = 1; redirect = 0; redirect_pc = 0;
        tick();
        reset = 0;
        tick();
        chk("prog.start_iaddr", iaddr, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            $display("prog word %0d: inst_pc=%0d inst_out=%h halted=%0b", k, inst_pc, inst_out, halted);
            chk($sformatf("prog%0d.valid", k), {31'b0, inst_valid}, 32'd1);
            chk($sformatf("prog%0d.inst_pc", k), inst_pc, 32'(4 * k));
            chk($sformatf("prog%0d.inst_out", k), inst_out, mem_word(32'(4 * k)));
            chk($sformatf("prog%0d.halted", k), {31'b0, halted}, (k == 9) ? 32'd1 : 32'd0);
        end
        chk("prog.count", fetch_count, 32'd10);
        tick();
        chk("prog.drained", {31'b0, inst_valid}, 32'd0);
        chk("prog.end_iaddr", iaddr, 32'd40);

        // ---------------- randomized traffic vs model ----------------
        for (int c = 0; c < 3000; c++) begin
            int sel;
            if (c == 0) reset = 1;
            else if (m_mode == M_DEAD) reset = ($urandom_range(0, 9) == 0);
            else reset = ($urandom_range(0, 199) == 0);
            run        = ($urandom_range(0, 9) != 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      redirect_pc = 32'(4 * $urandom_range(0, 9));
            else if (sel < 8) redirect_pc = 32'(4 * $urandom_range(0, 9) + $urandom_range(1, 3));
            else              redirect_pc = 32'(40 + 4 * $urandom_range(0, 100));
            if (redirect)
                $display("rand cyc=%0d redirect to %0d (reset=%0b run=%0b)", c, redirect_pc, reset, run);
            model_step();
            tick();
            chk("rand.iaddr", iaddr, m_pc);
            chk("rand.valid", {31'b0, inst_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("rand.halted", {31'b0, halted}, (m_mode == M_DONE) ? 32'd1 : 32'd0);
            chk("rand.fault", {31'b0, fault}, {31'b0, m_fault});
            chk("rand.fault_pc", fault_pc, m_fpc);
            chk("rand.count", fetch_count, m_cnt);
            if (mq.size() > 0) begin
                chk("rand.inst_pc", inst_pc, mq[0].pc);
                chk("rand.inst_out", inst_out, mq[0].w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Fetch sequencer for the byte-addressed, big-endian instruction memory (imemory). Owns the program counter, drives iaddr and captures the returned 32-bit word. Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. Handles branch/jump redirects, end-of-program, and misaligned or out-of-range targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
IMEM_BYTES, 40, bytes of loaded program; fetch stops at the last word below this limit.
Q_DEPTH, 2, fetch queue entries; fixed at 2 for this revision.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  fetch enable
iaddr  output  32  byte address to imemory; equals the PC register
instruction  input  32  word returned by imemory for iaddr, valid in the same cycle
inst_out  output  32  head-of-queue instruction
inst_pc  output  32  byte address of inst_out
inst_valid  output  1  queue non-empty
inst_ready  input  1  decode accepts the head; a pop occurs when inst_valid && inst_ready
redirect  input  1  branch/jump taken, single-cycle pulse
redirect_pc  input  32  redirect target byte address
halted  output  1  PC reached IMEM_BYTES; no further fetch
fault  output  1  sticky bad-redirect flag
fault_pc  output  32  offending redirect target
fetch_count  output  32  words pushed since reset, wraps at 2^32

Behaviour:
- Reset values: pc/iaddr=RESET_PC; queue empty; inst_valid=0; inst_out=0; inst_pc=0; halted=0; fault=0; fault_pc=0; fetch_count=0; state=IDLE.
- Reset applies on any cycle and overrides every other input, including mid-fetch or FAULT.
- States:
  - IDLE: no push. Go to FETCH on run=1.
  - FETCH: normal fetching (rules below).
  - END: program exhausted; halted=1; queue drains.
  - FAULT: bad redirect taken; fault=1; terminal until reset.
- Push condition in FETCH: run=1 and (count<2 or a pop occurs this cycle). On a push: enqueue {pc, instruction} sampled at the edge, then pc<=pc+4 and fetch_count++. Push and pop in the same cycle leave count unchanged.
- Fetch latency: the instruction at a given PC appears on inst_out 1 cycle after that PC is on iaddr, if the queue was empty.
- End of program: a push where pc+4 >= IMEM_BYTES enqueues that word, then moves to END. pc advances to pc+4 and is not fetched.
- run=0 in FETCH: go to IDLE. Queue and pc are retained.
- Redirect priority: reset > redirect > push/pop.
  - Redirect flushes the queue, so inst_valid=0 the next cycle.
  - A same-cycle pop is legal; its word is consumed by decode.
  - No push occurs in the redirect cycle.
- Valid redirect (redirect_pc[1:0]==0 and redirect_pc<IMEM_BYTES): pc<=redirect_pc.
  - FETCH or END: go to FETCH if run=1, else IDLE; halted clears.
  - IDLE: remain IDLE.
- Invalid redirect: go to FAULT; fault_pc<=redirect_pc; queue flushed; pc is frozen.
- In FAULT, later redirects are ignored.
- Queue outputs: when empty, inst_out and inst_pc hold their last value and are don't-care to decode.

Decomposition:
- Shared package ifetch_pkg: INSTR_W=32, ADDR_W=32, the state encoding (IDLE, FETCH, END, FAULT), and the word-alignment mask 2'b00.
- Sub-module ifetch_queue: 2-entry FIFO of {pc, instr} with push/pop/flush and count. Simultaneous push/pop is allowed when full; flush has priority.
- ifetch_ctrl instantiates ifetch_queue and imemory only in the bench. imemory sits outside this block.

Test Plan:
- Reset, run=1, inst_ready=1, program of 10 words at 0..36 -> inst_pc sequence 0,4,...,36 on consecutive cycles; halted=1 the cycle after pc 36 is pushed; fetch_count=10.
- inst_ready=0 for 5 cycles after start -> count saturates at 2 (pcs 0,4); iaddr holds 8. Then ready=1 -> pcs 0,4,8 in order, none lost or duplicated.
- redirect=1, redirect_pc=20 while the queue holds pcs 8,12 -> inst_valid=0 next cycle; next delivered inst_pc=20, then 24.
- redirect_pc=22 (misaligned), then separately redirect_pc=40 -> fault=1, fault_pc=22 (or 40); no further pushes; a later redirect to 0 is ignored until reset.
- In END with the queue drained, redirect_pc=8 -> halted=0, fetching resumes at 8. Assert reset mid-FETCH -> next cycle iaddr=0, inst_valid=0, fetch_count=0.
